// File: rtl/alu_writeback.sv
// Commit stage for the f8 ALU: updates C/Z/N flags, pulses the register-file write,
// and sequences 8- or 16-bit stores as little-endian byte writes.
module alu_writeback #(
  parameter int AW     = 16,
  parameter int RSEL_W = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       in_result_reg,
  input  logic [15:0]       in_result_mem,
  input  logic              in_z,
  input  logic              in_n,
  input  logic              in_c,
  input  logic [2:0]        in_flag_mask,
  input  logic              in_wide,
  input  logic              in_reg_we,
  input  logic [RSEL_W-1:0] in_reg_sel,
  input  logic              in_mem_we,
  input  logic [AW-1:0]     in_mem_addr,
  input  logic              flag_ld,
  input  logic [2:0]        flag_ld_val,
  output logic              flag_c,
  output logic              flag_z,
  output logic              flag_n,
  output logic              rf_we,
  output logic [RSEL_W-1:0] rf_sel,
  output logic              rf_wide,
  output logic [15:0]       rf_data,
  output logic              mem_req,
  output logic [AW-1:0]     mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic              mem_ack,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, WB, MEM_LO, MEM_HI} state_e;

  state_e              state_q, state_d;
  logic [15:0]         res_reg_q, res_mem_q;
  logic                wide_q, reg_we_q, mem_we_q;
  logic [RSEL_W-1:0]   sel_q;
  logic [AW-1:0]       addr_q;
  logic [2:0]          flags_q, flags_d;  // {c,z,n}
  logic                accept;

  assign accept = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = WB;
      WB:      state_d = mem_we_q ? MEM_LO : IDLE;
      MEM_LO:  if (mem_ack) state_d = wide_q ? MEM_HI : IDLE;
      MEM_HI:  if (mem_ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // flag_ld overrides every bit of a same-edge masked ALU update
  always_comb begin
    flags_d = flags_q;
    if (accept) begin
      if (in_flag_mask[2]) flags_d[2] = in_c;
      if (in_flag_mask[1]) flags_d[1] = in_z;
      if (in_flag_mask[0]) flags_d[0] = in_n;
    end
    if (flag_ld) flags_d = flag_ld_val;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      flags_q   <= 3'b000;
      res_reg_q <= '0;
      res_mem_q <= '0;
      wide_q    <= 1'b0;
      reg_we_q  <= 1'b0;
      mem_we_q  <= 1'b0;
      sel_q     <= '0;
      addr_q    <= '0;
    end else begin
      state_q <= state_d;
      flags_q <= flags_d;
      if (accept) begin
        res_reg_q <= in_result_reg;
        res_mem_q <= in_result_mem;
        wide_q    <= in_wide;
        reg_we_q  <= in_reg_we;
        mem_we_q  <= in_mem_we;
        sel_q     <= in_reg_sel;
        addr_q    <= in_mem_addr;
      end
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign flag_c    = flags_q[2];
  assign flag_z    = flags_q[1];
  assign flag_n    = flags_q[0];
  assign rf_we     = (state_q == WB) && reg_we_q;
  assign rf_sel    = sel_q;
  assign rf_wide   = wide_q;
  assign rf_data   = res_reg_q;
  assign mem_req   = (state_q == MEM_LO) || (state_q == MEM_HI);
  // high byte goes to addr+1, wrapping modulo 2^AW
  assign mem_addr  = (state_q == MEM_HI) ? addr_q + AW'(1) : addr_q;
  assign mem_wdata = (state_q == MEM_HI) ? res_mem_q[15:8] : res_mem_q[7:0];

endmodule
